// File: rtl/gate_tester_if.sv
`default_nettype none
// =====================================================================
// Module : gate_tester_if
// Brief  : Handshake/stimulus/result bundle between gate_tester and the
//          gate device it exercises.
// Rev    : 1.0 - initial release
// =====================================================================
interface gate_tester_if;
    logic       start;
    logic [6:0] dut_out;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_vec;
    logic [3:0] fail_count;

    modport master (
        input  start, dut_out,
        output a, b, c, busy, done, pass, fail_vec, fail_count
    );

    modport slave (
        output start, dut_out,
        input  a, b, c, busy, done, pass, fail_vec, fail_count
    );
endinterface
`default_nettype wire

// File: rtl/gate_tester.sv
`default_nettype none
// =====================================================================
// Module : gate_tester
// Brief  : Walks {a,b,c} through all 8 combinations and checks the seven
//          gate responses. Macro GATE_TESTER_STOP_ON_FAIL_EN ends a run
//          at the first mismatching combination.
// Rev    : 1.0 - initial release
// =====================================================================
module gate_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    gate_tester_if.master    gateBus
);

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [2:0] c_LAST_COMBO  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [2:0] r_combo;
    logic [2:0] w_comboNext;
    logic [3:0] r_settleCnt;
    logic [3:0] w_settleCntNext;
    logic [7:0] r_failVec;
    logic [7:0] w_failVecNext;
    logic [3:0] r_failCount;
    logic [3:0] w_failCountNext;
    logic       r_pass;
    logic       w_passNext;

    logic       w_a;
    logic       w_b;
    logic       w_c;
    logic [6:0] w_expected;
    logic       w_mismatch;
    logic       w_stopNow;
    logic [3:0] w_countAfter;

    assign w_a = r_combo[2];
    assign w_b = r_combo[1];
    assign w_c = r_combo[0];

    assign w_expected = {
        ~(w_a ^ w_b ^ w_c),
        w_a ^ w_b ^ w_c,
        ~(w_a | w_b | w_c),
        ~(w_a & w_b & w_c),
        ~w_a,
        w_a | w_b | w_c,
        w_a & w_b & w_c
    };

    // Case inequality so that undriven or unknown response bits fail the compare.
    assign w_mismatch   = (gateBus.dut_out !== w_expected);
    assign w_countAfter = r_failCount + {3'b000, w_mismatch};

`ifdef GATE_TESTER_STOP_ON_FAIL_EN
    assign w_stopNow = w_mismatch || (r_combo == c_LAST_COMBO);
`else
    assign w_stopNow = (r_combo == c_LAST_COMBO);
`endif

    always_comb begin
        w_stateNext     = r_state;
        w_comboNext     = r_combo;
        w_settleCntNext = r_settleCnt;
        w_failVecNext   = r_failVec;
        w_failCountNext = r_failCount;
        w_passNext      = r_pass;

        unique case (r_state)
            S_IDLE: begin
                if (gateBus.start) begin
                    w_stateNext     = S_SETTLE;
                    w_comboNext     = 3'd0;
                    w_settleCntNext = c_SETTLE_LOAD;
                    w_failVecNext   = 8'd0;
                    w_failCountNext = 4'd0;
                    w_passNext      = 1'b0;
                end
            end

            S_SETTLE: begin
                w_settleCntNext = r_settleCnt - 4'd1;
                if (r_settleCnt == 4'd1) begin
                    w_stateNext = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_mismatch) begin
                    w_failVecNext   = r_failVec | (8'd1 << r_combo);
                    w_failCountNext = w_countAfter;
                end
                if (w_stopNow) begin
                    w_stateNext = S_DONE;
                    w_passNext  = (w_countAfter == 4'd0);
                end else begin
                    w_stateNext     = S_SETTLE;
                    w_comboNext     = r_combo + 3'd1;
                    w_settleCntNext = c_SETTLE_LOAD;
                end
            end

            S_DONE: begin
                w_stateNext = S_IDLE;
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_combo     <= 3'd0;
            r_settleCnt <= 4'd0;
            r_failVec   <= 8'd0;
            r_failCount <= 4'd0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_combo     <= w_comboNext;
            r_settleCnt <= w_settleCntNext;
            r_failVec   <= w_failVecNext;
            r_failCount <= w_failCountNext;
            r_pass      <= w_passNext;
        end
    end

    assign gateBus.a          = w_a;
    assign gateBus.b          = w_b;
    assign gateBus.c          = w_c;
    assign gateBus.busy       = (r_state != S_IDLE);
    assign gateBus.done       = (r_state == S_DONE);
    assign gateBus.pass       = r_pass;
    assign gateBus.fail_vec   = r_failVec;
    assign gateBus.fail_count = r_failCount;

endmodule
`default_nettype wire

// File: tb/tb_gate_tester.sv
`default_nettype none
// =====================================================================
// Module : tb_gate_tester
// Brief  : Self-checking bench for gate_tester with a fault-injectable
//          gate stub and a run-timeline reference model.
// Rev    : 1.0 - initial release
// =====================================================================
`timescale 1ns/1ps
module tb_gate_tester;

    localparam int S  = 2;
    localparam int S1 = S + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_tester_if gtBus();

    gate_tester #(.SETTLE_CYCLES(S)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gateBus (gtBus.master)
    );

    int checks = 0;
    int failures = 0;

    logic [6:0] faultTable [8];

    function automatic logic [6:0] golden(input int k);
        int av, bv, cv, ones;
        logic [6:0] r;
        av = (k >> 2) & 1;
        bv = (k >> 1) & 1;
        cv = k & 1;
        ones = av + bv + cv;
        r[0] = (ones == 3);
        r[1] = (ones > 0);
        r[2] = (av == 0);
        r[3] = (ones != 3);
        r[4] = (ones == 0);
        r[5] = (ones % 2 == 1);
        r[6] = (ones % 2 == 0);
        return r;
    endfunction

    // Gate device stub: the correct truth table with per-combination corruption.
    always_comb begin
        gtBus.dut_out = golden(int'({gtBus.a, gtBus.b, gtBus.c})) ^ faultTable[{gtBus.a, gtBus.b, gtBus.c}];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: run timeline measured in clock edges since the start edge.
    bit         modelValid = 0;
    bit         running = 0;
    int         n = 0;
    int         runLen = 0;
    bit         fails [8];
    logic [2:0] heldCombo = 3'd0;
    logic [7:0] heldVec = 8'd0;
    logic [3:0] heldCount = 4'd0;
    logic       heldPass = 1'b0;

    function automatic int comboAt(input int nn);
        return (nn < runLen) ? nn / S1 : runLen / S1 - 1;
    endfunction

    function automatic logic [7:0] vecAt(input int nn);
        logic [7:0] v;
        v = 8'd0;
        for (int j = 0; j < 8; j++) begin
            if (fails[j] && (j + 1) * S1 <= nn && j < runLen / S1) v[j] = 1'b1;
        end
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            modelValid = 1;
            running    = 0;
            heldCombo  = 3'd0;
            heldVec    = 8'd0;
            heldCount  = 4'd0;
            heldPass   = 1'b0;
        end else if (running) begin
            if (n == runLen) begin
                running   = 0;
                heldCombo = 3'(comboAt(n));
                heldVec   = vecAt(n);
                heldCount = 4'($countones(heldVec));
                heldPass  = (heldVec == 8'd0);
            end else begin
                n++;
            end
        end else if (gtBus.start) begin
            int firstFail;
            running   = 1;
            n         = 0;
            firstFail = -1;
            for (int k = 0; k < 8; k++) begin
                fails[k] = ((golden(k) ^ faultTable[k]) != golden(k));
                if (fails[k] && firstFail < 0) firstFail = k;
            end
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
            runLen = (firstFail >= 0) ? (firstFail + 1) * S1 : 8 * S1;
`else
            runLen = 8 * S1;
`endif
        end
    end

    initial forever begin
        logic [2:0] eC;
        logic [7:0] eVec;
        logic [3:0] eCnt;
        logic       eBusy, eDone, ePass;
        @(negedge clk);
        if (modelValid) begin
            if (running) begin
                eC    = 3'(comboAt(n));
                eBusy = 1'b1;
                eDone = (n == runLen);
                eVec  = vecAt(n);
                eCnt  = 4'($countones(eVec));
                ePass = (n == runLen) && (eVec == 8'd0);
            end else begin
                eC    = heldCombo;
                eBusy = 1'b0;
                eDone = 1'b0;
                eVec  = heldVec;
                eCnt  = heldCount;
                ePass = heldPass;
            end
            check("abc",        {gtBus.a, gtBus.b, gtBus.c}, eC);
            check("busy",       gtBus.busy, eBusy);
            check("done",       gtBus.done, eDone);
            check("fail_vec",   gtBus.fail_vec, eVec);
            check("fail_count", gtBus.fail_count, eCnt);
            check("pass",       gtBus.pass, ePass);
        end
    end

    task automatic waitIdle();
        int cnt;
        cnt = 0;
        while (gtBus.busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("idle_timeout", gtBus.busy, 1'b0);
    endtask

    task automatic runOnce(input string tag, input logic [7:0] xVec, input int xCnt,
                           input logic xPass, input int xCycles, input logic [2:0] xCombo);
        int cnt;
        @(negedge clk);
        gtBus.start = 1'b1;
        @(negedge clk);
        gtBus.start = 1'b0;
        cnt = 0;
        while (!gtBus.done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_cycles"}, cnt, xCycles);
        check({tag, "_vec"},    gtBus.fail_vec, xVec);
        check({tag, "_count"},  gtBus.fail_count, xCnt);
        check({tag, "_pass"},   gtBus.pass, xPass);
        check({tag, "_combo"},  {gtBus.a, gtBus.b, gtBus.c}, xCombo);
    endtask

    initial begin
        int dones;
        gtBus.start = 1'b0;
        for (int k = 0; k < 8; k++) faultTable[k] = 7'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_busy", gtBus.busy, 1'b0);
        check("rst_abc",  {gtBus.a, gtBus.b, gtBus.c}, 3'd0);
        check("rst_vec",  gtBus.fail_vec, 8'd0);
        check("rst_cnt",  gtBus.fail_count, 4'd0);

        runOnce("good", 8'h00, 0, 1'b1, 8 * S1, 3'd7);
        check("good_hold_pass", gtBus.pass, 1'b1);

        waitIdle();
        for (int k = 0; k < 8; k++) faultTable[k] = golden(k)[5] ? 7'h20 : 7'h00;
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
        runOnce("xor0", 8'h02, 1, 1'b0, 2 * S1, 3'd1);
`else
        runOnce("xor0", 8'h96, 4, 1'b0, 8 * S1, 3'd7);
`endif

        waitIdle();
        for (int k = 0; k < 8; k++) faultTable[k] = golden(k)[2] ? 7'h00 : 7'h04;
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
        runOnce("not1", 8'h10, 1, 1'b0, 5 * S1, 3'd4);
`else
        runOnce("not1", 8'hF0, 4, 1'b0, 8 * S1, 3'd7);
`endif

        // Abort in the middle of combination 3, then a clean full run.
        waitIdle();
        for (int k = 0; k < 8; k++) faultTable[k] = 7'd0;
        @(negedge clk);
        gtBus.start = 1'b1;
        @(negedge clk);
        gtBus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_combo3", {gtBus.a, gtBus.b, gtBus.c}, 3'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", gtBus.busy, 1'b0);
        check("abort_abc",  {gtBus.a, gtBus.b, gtBus.c}, 3'd0);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (gtBus.done) dones++;
        end
        check("abort_nodone", dones, 0);
        runOnce("after_abort", 8'h00, 0, 1'b1, 8 * S1, 3'd7);

        // Start held high across DONE launches back-to-back runs.
        waitIdle();
        @(negedge clk);
        gtBus.start = 1'b1;
        dones = 0;
        repeat (55) begin
            @(negedge clk);
            if (gtBus.done) dones++;
        end
        gtBus.start = 1'b0;
        check("held_start_dones", dones, 2);
        waitIdle();

        // Randomized runs with random faults, start noise and occasional resets.
        for (int r = 0; r < 25; r++) begin
            gtBus.start = 1'b0;
            waitIdle();
            for (int k = 0; k < 8; k++) begin
                faultTable[k] = ($urandom % 3 == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            end
            gtBus.start = 1'b1;
            @(negedge clk);
            repeat (30 + $urandom % 10) begin
                gtBus.start = ($urandom % 4 == 0);
                rst_n = ($urandom % 150 != 0);
                @(negedge clk);
            end
            rst_n = 1'b1;
        end
        gtBus.start = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
